pixel_burst_writer: RTL and testbench

- Sits between the Mandelbrot rendering engine and DDR2 video RAM port 0, in the clk0 domain.
- Accepts 32-bit point results from the engine and packs pixel pairs into 64-bit words.
- Pushes those words into the MIG p0 write FIFO, then issues write commands in fixed bursts at linearly increasing byte addresses.
- Owns the frame-buffer address pointer and signals when a complete frame has been committed to memory.

---
 rtl/pixel_burst_writer.sv | 204 ++++++++++++++++++++
 tb/tb_pixel_burst_writer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_burst_writer.sv
// pixel_burst_writer: packs 32-bit engine pixels into 64-bit words, pushes
// them into the MIG p0 write FIFO and issues fixed-size write bursts at
// linearly increasing byte addresses. It signals when a whole frame has been
// committed.
// Optional double buffering is enabled with `define PBW_DOUBLE_BUFFER_EN.
// With it, frames alternate between BASE_ADDR and BASE_ADDR + FRAME_WORDS*8.
// pix_ready is decoded from the registered state and the live FIFO flags,
// so a pair is never completed into a FIFO that reports full. Every other
// output comes straight from a register.
module pixel_burst_writer #(
  parameter int          BURST_WORDS = 16,
  parameter int          FRAME_WORDS = 153600,
  parameter logic [29:0] BASE_ADDR   = 30'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        calib_done,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [31:0] pix_data,
  output logic        pix_ready,
  output logic        wr_en,
  output logic [63:0] wr_data,
  output logic [7:0]  wr_mask,
  input  logic        wr_full,
  input  logic [6:0]  wr_count,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        busy,
  output logic        frame_done,
  output logic        front_buf
);

  localparam int             WCW        = $clog2(FRAME_WORDS + 1);
  localparam logic [WCW-1:0] FRAME_LAST = WCW'(FRAME_WORDS);
  localparam logic [5:0]     BURST_LAST = 6'(BURST_WORDS);
`ifdef PBW_DOUBLE_BUFFER_EN
  localparam logic [29:0]    BUF1_ADDR  = BASE_ADDR + 30'(FRAME_WORDS * 8);
`endif

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CMD, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [29:0]      addr_reg, addr_next;
  logic [WCW-1:0]   word_cnt_reg, word_cnt_next;
  logic [5:0]       burst_cnt_reg, burst_cnt_next;
  logic             half_reg, half_next;
  logic [31:0]      low_reg, low_next;
  logic             wr_en_reg, wr_en_next;
  logic [63:0]      wr_data_reg, wr_data_next;
  logic             cmd_en_reg, cmd_en_next;
  logic [5:0]       cmd_bl_reg, cmd_bl_next;
  logic [29:0]      cmd_addr_reg, cmd_addr_next;
  logic             busy_reg, busy_next;
  logic             frame_done_reg, frame_done_next;
  logic [29:0]      frame_base;
  logic             go_cmd;
  logic             fifo_ok;
`ifdef PBW_DOUBLE_BUFFER_EN
  logic             buf_sel_reg, buf_sel_next;
  logic             front_buf_reg, front_buf_next;
`endif

`ifdef PBW_DOUBLE_BUFFER_EN
  assign frame_base = buf_sel_reg ? BUF1_ADDR : BASE_ADDR;
  assign front_buf  = front_buf_reg;
`else
  assign frame_base = BASE_ADDR;
  assign front_buf  = 1'b0;
`endif

  assign wr_en         = wr_en_reg;
  assign wr_data       = wr_data_reg;
  assign wr_mask       = 8'h00;
  assign cmd_en        = cmd_en_reg;
  assign cmd_instr     = 3'b000;
  assign cmd_bl        = cmd_bl_reg;
  assign cmd_byte_addr = cmd_addr_reg;
  assign busy          = busy_reg;
  assign frame_done    = frame_done_reg;

  // Next-state, datapath and pix_ready decode for the frame FSM.
  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    word_cnt_next   = word_cnt_reg;
    burst_cnt_next  = burst_cnt_reg;
    half_next       = half_reg;
    low_next        = low_reg;
    wr_en_next      = 1'b0;
    wr_data_next    = wr_data_reg;
    cmd_en_next     = 1'b0;
    cmd_bl_next     = cmd_bl_reg;
    cmd_addr_next   = cmd_addr_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    pix_ready       = 1'b0;
`ifdef PBW_DOUBLE_BUFFER_EN
    buf_sel_next    = buf_sel_reg;
    front_buf_next  = front_buf_reg;
`endif
    // A burst is due when it is full or when the frame's last word is in.
    go_cmd  = (burst_cnt_reg == BURST_LAST) || (word_cnt_reg == FRAME_LAST);
    // Headroom of one word covers the push that lands a cycle after acceptance.
    fifo_ok = !wr_full && (wr_count <= 7'd62);

    unique case (state_reg)
      S_IDLE: begin
        if (frame_start && calib_done) begin
          addr_next      = frame_base;
          word_cnt_next  = '0;
          burst_cnt_next = 6'd0;
          half_next      = 1'b0;
          busy_next      = 1'b1;
          state_next     = S_FILL;
        end
      end
      S_FILL: begin
        if (go_cmd) begin
          cmd_bl_next   = burst_cnt_reg - 6'd1;
          cmd_addr_next = addr_reg;
          state_next    = S_CMD;
        end else begin
          pix_ready = !half_reg || fifo_ok;
          if (pix_valid && pix_ready) begin
            if (!half_reg) begin
              low_next  = pix_data;
              half_next = 1'b1;
            end else begin
              wr_data_next   = {pix_data, low_reg};
              wr_en_next     = 1'b1;
              half_next      = 1'b0;
              burst_cnt_next = burst_cnt_reg + 6'd1;
              word_cnt_next  = word_cnt_reg + WCW'(1);
            end
          end
        end
      end
      S_CMD: begin
        if (!cmd_full) begin
          cmd_en_next    = 1'b1;
          addr_next      = addr_reg + {21'd0, burst_cnt_reg, 3'b000};
          burst_cnt_next = 6'd0;
          state_next     = (word_cnt_reg == FRAME_LAST) ? S_DONE : S_FILL;
        end
      end
      S_DONE: begin
        frame_done_next = 1'b1;
        busy_next       = 1'b0;
`ifdef PBW_DOUBLE_BUFFER_EN
        front_buf_next  = buf_sel_reg;
        buf_sel_next    = ~buf_sel_reg;
`endif
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any partially built burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      addr_reg       <= 30'd0;
      word_cnt_reg   <= '0;
      burst_cnt_reg  <= 6'd0;
      half_reg       <= 1'b0;
      low_reg        <= 32'd0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= 64'd0;
      cmd_en_reg     <= 1'b0;
      cmd_bl_reg     <= 6'd0;
      cmd_addr_reg   <= 30'd0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
`ifdef PBW_DOUBLE_BUFFER_EN
      buf_sel_reg    <= 1'b0;
      front_buf_reg  <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      word_cnt_reg   <= word_cnt_next;
      burst_cnt_reg  <= burst_cnt_next;
      half_reg       <= half_next;
      low_reg        <= low_next;
      wr_en_reg      <= wr_en_next;
      wr_data_reg    <= wr_data_next;
      cmd_en_reg     <= cmd_en_next;
      cmd_bl_reg     <= cmd_bl_next;
      cmd_addr_reg   <= cmd_addr_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
`ifdef PBW_DOUBLE_BUFFER_EN
      buf_sel_reg    <= buf_sel_next;
      front_buf_reg  <= front_buf_next;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_burst_writer.sv
// Bench for pixel_burst_writer. A reference model derives the expected
// 64-bit word stream from the accepted pixels and the burst command list
// from the frame geometry. Both follow `define PBW_DOUBLE_BUFFER_EN.
module tb_pixel_burst_writer;

  localparam int          BW   = 4;
  localparam int          FW   = 10;
  localparam logic [29:0] BASE = 30'd0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        calib_done, frame_start, pix_valid;
  logic [31:0] pix_data;
  logic        pix_ready, wr_en;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic        wr_full;
  logic [6:0]  wr_count;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_full, busy, frame_done, front_buf;

  pixel_burst_writer #(.BURST_WORDS(BW), .FRAME_WORDS(FW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .wr_count(wr_count), .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .busy(busy),
    .frame_done(frame_done), .front_buf(front_buf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [5:0]  bl;
    int          end_w;
  } cmd_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs
  int          valid_pct = 100, full_pct = 0, cfull_pct = 0;
  int          hold_wr_full = 0, hold_cmd_full = 0;
  bit          seq_mode = 1'b1, fs_req = 1'b0, cal_rand = 1'b0, cal_level = 1'b1;
  bit          acc_flag = 1'b0;
  logic [31:0] next_val = 32'd1;

  // Reference model state
  bit          model_busy = 1'b0, next_buf = 1'b0, cur_buf = 1'b0, model_front = 1'b0;
  logic [31:0] pix_q[$];
  logic [63:0] word_q[$];
  cmd_t        exp_cmds[$];
  cmd_t        cmd_log[$];
  int          words_pushed = 0, words_acc = 0, cmds_done = 0, done_cnt = 0;
  bit          pend_prev = 1'b0, prev_cmd_full = 1'b0, prev_cmd_en = 1'b0;
  logic [63:0] last_wr_data = 64'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_pix_ready"}, pix_ready, 0);
    check_val({tag, "_wr_en"}, wr_en, 0);
    check_val({tag, "_wr_data"}, wr_data, 0);
    check_val({tag, "_wr_mask"}, wr_mask, 0);
    check_val({tag, "_cmd_en"}, cmd_en, 0);
    check_val({tag, "_cmd_instr"}, cmd_instr, 0);
    check_val({tag, "_cmd_bl"}, cmd_bl, 0);
    check_val({tag, "_cmd_addr"}, cmd_byte_addr, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_frame_done"}, frame_done, 0);
    check_val({tag, "_front_buf"}, front_buf, 0);
  endtask

  // Driver: inputs change 1 time unit after each rising edge.
  initial begin
    calib_done = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 32'd0;
    wr_full = 1'b0; wr_count = 7'd0; cmd_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      frame_start = fs_req;
      fs_req      = 1'b0;
      calib_done  = cal_rand ? 1'($urandom_range(0, 1)) : cal_level;
      pix_valid   = ($urandom_range(0, 99) < valid_pct);
      if (acc_flag) next_val = next_val + 32'd1;
      pix_data    = seq_mode ? next_val : $urandom;
      if (hold_wr_full > 0) begin
        wr_full = 1'b1;
        hold_wr_full--;
      end else begin
        wr_full = ($urandom_range(0, 99) < full_pct);
      end
      wr_count = wr_full ? 7'd64 : 7'($urandom_range(0, (full_pct > 0) ? 70 : 20));
      if (hold_cmd_full > 0) begin
        cmd_full = 1'b1;
        hold_cmd_full--;
      end else begin
        cmd_full = ($urandom_range(0, 99) < cfull_pct);
      end
    end
  end

  // Monitor and reference model, sampled on the falling edge.
  initial begin
    cmd_t c;
    bit   acc, blk;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        model_busy = 1'b0; next_buf = 1'b0; cur_buf = 1'b0; model_front = 1'b0;
        pix_q.delete(); word_q.delete(); exp_cmds.delete();
        words_pushed = 0; words_acc = 0; cmds_done = 0;
        pend_prev = 1'b0; prev_cmd_full = 1'b0; prev_cmd_en = 1'b0; acc_flag = 1'b0;
      end else begin
        // A pending command must present stable fields until it issues
        if (pend_prev) begin
          check_val("cmd_addr_hold", cmd_byte_addr, exp_cmds[0].addr);
          check_val("cmd_bl_hold", cmd_bl, exp_cmds[0].bl);
        end
        if (wr_en) begin
          words_pushed++;
          last_wr_data = wr_data;
          check_val("wr_mask", wr_mask, 0);
          if (word_q.size() == 0) check_val("wr_unexpected", 1, 0);
          else check_val("wr_data", wr_data, word_q.pop_front());
        end
        if (cmd_en) begin
          check_val("cmd_instr", cmd_instr, 0);
          check_val("cmd_en_while_full", prev_cmd_full, 0);
          c.addr = cmd_byte_addr; c.bl = cmd_bl; c.end_w = 0;
          cmd_log.push_back(c);
          if (exp_cmds.size() == 0) begin
            check_val("cmd_unexpected", 1, 0);
          end else begin
            c = exp_cmds.pop_front();
            check_val("cmd_addr", cmd_byte_addr, c.addr);
            check_val("cmd_bl", cmd_bl, c.bl);
            check_val("cmd_after_data", words_pushed >= c.end_w, 1);
            cmds_done++;
          end
        end
        if (frame_done) begin
          check_val("done_in_frame", model_busy, 1);
          check_val("done_after_last_cmd", prev_cmd_en, 1);
          check_val("done_cmds_left", exp_cmds.size(), 0);
          check_val("done_words", words_pushed, FW);
          model_busy = 1'b0;
`ifdef PBW_DOUBLE_BUFFER_EN
          model_front = cur_buf;
          next_buf    = ~cur_buf;
`endif
          done_cnt++;
        end
        check_val("busy", busy, model_busy);
        check_val("front_buf", front_buf, model_front);
        if (!model_busy) check_val("ready_idle", pix_ready, 0);
        acc = pix_valid && pix_ready;
        if (acc && model_busy) begin
          if (pix_q.size() == 1) check_val("acc_fifo_room", !wr_full && (wr_count <= 7'd62), 1);
          blk = (words_acc == FW) ||
                (words_acc > 0 && (words_acc % BW) == 0 && cmds_done * BW < words_acc);
          check_val("acc_during_cmd", blk, 0);
          pix_q.push_back(pix_data);
          if (pix_q.size() == 2) begin
            word_q.push_back({pix_q[1], pix_q[0]});
            pix_q.delete();
            words_acc++;
          end
        end
        acc_flag = acc;
        if (frame_start && calib_done && !model_busy) begin
          model_busy = 1'b1;
          cur_buf    = next_buf;
          exp_cmds.delete(); pix_q.delete(); word_q.delete();
          words_pushed = 0; words_acc = 0; cmds_done = 0;
          for (int w = 0; w < FW; w += BW) begin
            int n;
            n = (FW - w < BW) ? (FW - w) : BW;
            c.addr  = (cur_buf ? BASE + 30'(FW * 8) : BASE) + 30'(w * 8);
            c.bl    = 6'(n - 1);
            c.end_w = w + n;
            exp_cmds.push_back(c);
          end
        end
        pend_prev     = (exp_cmds.size() > 0) && (words_pushed >= exp_cmds[0].end_w);
        prev_cmd_full = cmd_full;
        prev_cmd_en   = cmd_en;
      end
    end
  end

  task automatic start_frame();
    int t;
    fs_req = 1'b1;
    t = 0;
    while (!model_busy && t < 20) begin @(posedge clk); t++; end
    check_val("frame_started", model_busy, 1);
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (done_cnt <= prev && t < 3000) begin @(posedge clk); t++; end
    check_val("frame_completed", done_cnt > prev, 1);
  endtask

  task automatic wait_words(input int n, input string tag);
    int t;
    t = 0;
    while (words_pushed < n && t < 500) begin @(posedge clk); t++; end
    check_val(tag, words_pushed >= n, 1);
  endtask

  task automatic check_cmd_log(input string tag, input logic [29:0] base);
    check_val({tag, "_ncmd"}, cmd_log.size(), 3);
    if (cmd_log.size() == 3) begin
      check_val({tag, "_a0"}, cmd_log[0].addr, base);
      check_val({tag, "_b0"}, cmd_log[0].bl, 3);
      check_val({tag, "_a1"}, cmd_log[1].addr, base + 30'd32);
      check_val({tag, "_b1"}, cmd_log[1].bl, 3);
      check_val({tag, "_a2"}, cmd_log[2].addr, base + 30'd64);
      check_val({tag, "_b2"}, cmd_log[2].bl, 1);
    end
  endtask

  initial begin
    logic [29:0] f2_base;
    int          d;
`ifdef PBW_DOUBLE_BUFFER_EN
    f2_base = 30'd80;
`else
    f2_base = 30'd0;
`endif
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #2 check_outputs_zero("reset");

    // Frame 1: pixels 1..20 back to back
    seq_mode = 1'b1; next_val = 32'd1; valid_pct = 100;
    cmd_log.delete();
    d = done_cnt;
    start_frame();
    wait_done(d);
    #2;
    check_val("f1_last_word", last_wr_data, 64'h00000014_00000013);
    check_cmd_log("f1", 30'd0);
    check_val("f1_front", front_buf, 0);
    check_val("f1_busy_after", busy, 0);

    // frame_start without calibration is dropped
    cal_level = 1'b0; fs_req = 1'b1;
    d = done_cnt;
    repeat (12) @(posedge clk);
    #2;
    check_val("nocal_busy", busy, 0);
    check_val("nocal_no_words", words_pushed, FW);
    cal_level = 1'b1;

    // Frame 2: write-FIFO stall mid-burst, command FIFO stall, ignored restart
    next_val = 32'd1; cmd_log.delete();
    d = done_cnt;
    start_frame();
    wait_words(2, "f2_two_words");
    hold_wr_full = 6;
    wait_words(4, "f2_four_words");
    hold_cmd_full = 5;
    for (int i = 0; i < 5; i++) begin
      #2 check_val("cfull_no_cmd_en", cmd_en, 0);
      @(posedge clk);
    end
    begin
      int t;
      t = 0;
      while (cmd_log.size() < 1 && t < 20) begin @(posedge clk); t++; end
    end
    fs_req = 1'b1;
    wait_done(d);
    #2;
    check_val("f2_last_word", last_wr_data, 64'h00000014_00000013);
    check_cmd_log("f2", f2_base);
`ifdef PBW_DOUBLE_BUFFER_EN
    check_val("f2_front", front_buf, 1);
`else
    check_val("f2_front", front_buf, 0);
`endif

    // Randomised frames with back-pressure and calib_done glitches
    seq_mode = 1'b0; valid_pct = 70; full_pct = 15; cfull_pct = 20;
    for (int f = 0; f < 6; f++) begin
      d = done_cnt;
      start_frame();
      cal_rand = 1'b1;
      wait_done(d);
      cal_rand = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Reset in the middle of a frame
    d = done_cnt;
    start_frame();
    wait_words(3, "mid_words");
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_outputs_zero("midrst");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Next frame restarts from buffer 0
    seq_mode = 1'b1; next_val = 32'd1; valid_pct = 100; full_pct = 0; cfull_pct = 0;
    repeat (2) @(posedge clk);
    cmd_log.delete();
    d = done_cnt;
    start_frame();
    wait_done(d);
    #2;
    check_cmd_log("after_rst", 30'd0);
    check_val("after_rst_front", front_buf, 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
